// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with debounce and one-cycle key pulse.
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_scan #(
  parameter int SCAN_DIV         = 50000,
  parameter int DEBOUNCE_SAMPLES = 10,
  parameter int REPEAT_DELAY     = 50,
  parameter int REPEAT_RATE      = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       keyboard_en,
  output logic [3:0] keyboard_num,
  output logic       key_held
);

  typedef enum logic [1:0] {
    SCAN, DEB_PRESS, HELD, DEB_REL
  } state_t;

  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_N = CW'(DEBOUNCE_SAMPLES);

  if (SCAN_DIV < 1 || DEBOUNCE_SAMPLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
    $error("keypad_scan: parameters must be >= 1");
  end

  logic [3:0]    row_s1, row_s2;
  logic [DW-1:0] div_cnt;
  state_t        state, state_d;
  logic [1:0]    col_idx, col_idx_d;
  logic [1:0]    r_idx, r_idx_d;
  logic [1:0]    c_idx, c_idx_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          en_q, en_d;
  logic [3:0]    num_q, num_d;
  logic          held_q, held_d;
  logic [1:0]    low_idx;
  logic          sample;

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX =
    (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);
  logic [RW-1:0] rpt_cnt, rpt_cnt_d;
  logic          rpt_first, rpt_first_d;
`endif

  assign sample = (div_cnt == DIV_LAST);

  // Lowest active row wins when several rows are low together.
  always_comb begin
    low_idx = 2'd0;
    priority case (1'b1)
      !row_s2[0]: low_idx = 2'd0;
      !row_s2[1]: low_idx = 2'd1;
      !row_s2[2]: low_idx = 2'd2;
      !row_s2[3]: low_idx = 2'd3;
      default:    low_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1  <= 4'hF;
      row_s2  <= 4'hF;
      div_cnt <= '0;
      state   <= SCAN;
      col_idx <= 2'd0;
      r_idx   <= 2'd0;
      c_idx   <= 2'd0;
      cnt     <= '0;
      en_q    <= 1'b0;
      num_q   <= 4'h0;
      held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
`endif
    end else begin
      row_s1  <= row;
      row_s2  <= row_s1;
      div_cnt <= sample ? '0 : div_cnt + 1'b1;
      state   <= state_d;
      col_idx <= col_idx_d;
      r_idx   <= r_idx_d;
      c_idx   <= c_idx_d;
      cnt     <= cnt_d;
      en_q    <= en_d;
      num_q   <= num_d;
      held_q  <= held_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt   <= rpt_cnt_d;
      rpt_first <= rpt_first_d;
`endif
    end
  end

  always_comb begin
    state_d   = state;
    col_idx_d = col_idx;
    r_idx_d   = r_idx;
    c_idx_d   = c_idx;
    cnt_d     = cnt;
    en_d      = 1'b0;
    num_d     = num_q;
    held_d    = held_q;
`ifdef KEYPAD_REPEAT_EN
    rpt_cnt_d   = rpt_cnt;
    rpt_first_d = rpt_first;
`endif
    if (sample) begin
      unique case (state)
        SCAN: begin
          if (&row_s2) begin
            col_idx_d = col_idx + 2'd1;
          end else begin
            r_idx_d = low_idx;
            c_idx_d = col_idx;
            cnt_d   = CW'(1);
            state_d = DEB_PRESS;
          end
        end
        DEB_PRESS: begin
          if (!row_s2[r_idx]) begin
            cnt_d = cnt + 1'b1;
          end else begin
            cnt_d     = '0;
            col_idx_d = col_idx + 2'd1;
            state_d   = SCAN;
          end
        end
        HELD: begin
          if (row_s2[r_idx]) begin
            cnt_d   = CW'(1);
            state_d = DEB_REL;
          end else begin
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_d = rpt_cnt + 1'b1;
            if (rpt_cnt_d == (rpt_first ? RW'(REPEAT_DELAY)
                                        : RW'(REPEAT_RATE))) begin
              en_d        = 1'b1;
              rpt_cnt_d   = '0;
              rpt_first_d = 1'b0;
            end
`endif
          end
        end
        DEB_REL: begin
          if (row_s2[r_idx]) begin
            cnt_d = cnt + 1'b1;
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
      // Press/release acceptance also covers DEBOUNCE_SAMPLES==1.
      if (state_d == DEB_PRESS && cnt_d == DEB_N) begin
        en_d    = 1'b1;
        num_d   = {r_idx_d, c_idx_d};
        held_d  = 1'b1;
        state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b1;
`endif
      end else if (state_d == DEB_REL && cnt_d == DEB_N) begin
        held_d    = 1'b0;
        cnt_d     = '0;
        col_idx_d = col_idx + 2'd1;
        state_d   = SCAN;
`ifdef KEYPAD_REPEAT_EN
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    col          = ~(4'b0001 << col_idx);
    keyboard_en  = en_q;
    keyboard_num = num_q;
    key_held     = held_q;
  end

endmodule
